// File: rtl/riscq_user_regs.sv
// -----------------------------------------------------------------------------
// riscq_user_regs
//
// User register bank shared by the RISC-Q core and an external host. It holds
// eight 32-bit registers. Each side has its own write port and its own
// combinational read port. All registers are also exposed in parallel,
// together with a one-cycle update strobe per register.
//
// Ports
//   i_clk        system clock; all state updates on the rising edge
//   i_rst        synchronous, active-high reset; clears registers and strobes
//   i_we_cpu     core write enable
//   i_waddr_cpu  core write address (8 bit); only 0..7 are decoded
//   i_wdata_cpu  core write data
//   i_raddr_cpu  core read address
//   o_rdata_cpu  core read data (combinational, no write bypass)
//   i_we_ext     host write enable
//   i_waddr_ext  host write address
//   i_wdata_ext  host write data
//   i_raddr_ext  host read address
//   o_rdata_ext  host read data (combinational, no write bypass)
//   o_regs       all registers concatenated; reg k at [32k+31:32k]
//   o_upd        bit k is high for one cycle after any accepted write to reg k
//
// Handshake: none. i_we_cpu and i_we_ext are single-cycle qualifiers. Every
// write they qualify completes at that rising edge and cannot be stalled.
// -----------------------------------------------------------------------------
module riscq_user_regs #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we_cpu,
    input  logic [7:0]                 i_waddr_cpu,
    input  logic [DATA_W-1:0]          i_wdata_cpu,
    input  logic [2:0]                 i_raddr_cpu,
    output logic [DATA_W-1:0]          o_rdata_cpu,
    input  logic                       i_we_ext,
    input  logic [2:0]                 i_waddr_ext,
    input  logic [DATA_W-1:0]          i_wdata_ext,
    input  logic [2:0]                 i_raddr_ext,
    output logic [DATA_W-1:0]          o_rdata_ext,
    output logic [NUM_REGS*DATA_W-1:0] o_regs,
    output logic [NUM_REGS-1:0]        o_upd
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] upd_q;
    logic [NUM_REGS-1:0] upd_d;
    logic                cpu_hit;

    // Core addresses 8..255 fall outside the bank and are dropped silently.
    assign cpu_hit = i_we_cpu && (i_waddr_cpu[7:3] == 5'd0);

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            upd_d[k]  = 1'b0;
            if (i_we_ext && (i_waddr_ext == 3'(k))) begin
                regs_d[k] = i_wdata_ext;
                upd_d[k]  = 1'b1;
            end
            // The core write is evaluated last, so it wins a same-register collision.
            if (cpu_hit && (i_waddr_cpu[2:0] == 3'(k))) begin
                regs_d[k] = i_wdata_cpu;
                upd_d[k]  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            upd_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            upd_q <= upd_d;
        end
    end

    // Reads see only the stored value. A write in the same cycle shows up next cycle.
    assign o_rdata_cpu = regs_q[i_raddr_cpu];
    assign o_rdata_ext = regs_q[i_raddr_ext];
    assign o_upd       = upd_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_view
        assign o_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_riscq_user_regs.sv
// -----------------------------------------------------------------------------
// tb_riscq_user_regs
//
// Directed bench for riscq_user_regs. A behavioural register-array model is
// stepped on each rising edge. A compare process checks every DUT output
// against this model on each falling edge. Hand-computed literal expectations
// at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_riscq_user_regs;

    // ---------------- clock / reset ----------------
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic         i_we_cpu = 1'b0;
    logic [7:0]   i_waddr_cpu = '0;
    logic [31:0]  i_wdata_cpu = '0;
    logic [2:0]   i_raddr_cpu = '0;
    logic [31:0]  o_rdata_cpu;
    logic         i_we_ext = 1'b0;
    logic [2:0]   i_waddr_ext = '0;
    logic [31:0]  i_wdata_ext = '0;
    logic [2:0]   i_raddr_ext = '0;
    logic [31:0]  o_rdata_ext;
    logic [255:0] o_regs;
    logic [7:0]   o_upd;

    riscq_user_regs dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we_cpu    (i_we_cpu),
        .i_waddr_cpu (i_waddr_cpu),
        .i_wdata_cpu (i_wdata_cpu),
        .i_raddr_cpu (i_raddr_cpu),
        .o_rdata_cpu (o_rdata_cpu),
        .i_we_ext    (i_we_ext),
        .i_waddr_ext (i_waddr_ext),
        .i_wdata_ext (i_wdata_ext),
        .i_raddr_ext (i_raddr_ext),
        .o_rdata_ext (o_rdata_ext),
        .o_regs      (o_regs),
        .o_upd       (o_upd)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers are a plain array. Strobes record "written at the last edge".
    // The host write is applied first and the core write second, so the core
    // write has the final word on a shared target.
    logic [31:0] m_regs [8];
    logic [7:0]  m_upd;

    initial begin
        for (int k = 0; k < 8; k++) m_regs[k] = '0;
        m_upd = '0;
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 8; k++) m_regs[k] = '0;
            m_upd = '0;
        end else begin
            m_upd = '0;
            if (i_we_ext) begin
                m_regs[i_waddr_ext] = i_wdata_ext;
                m_upd[i_waddr_ext]  = 1'b1;
            end
            if (i_we_cpu && i_waddr_cpu < 8'd8) begin
                m_regs[i_waddr_cpu[2:0]] = i_wdata_cpu;
                m_upd[i_waddr_cpu[2:0]]  = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge i_clk) begin
        if (check_en) begin
            logic [255:0] flat;
            for (int k = 0; k < 8; k++) flat[k*32 +: 32] = m_regs[k];
            check("mdl_regs", o_regs, flat);
            check("mdl_upd", {248'd0, o_upd}, {248'd0, m_upd});
            check("mdl_rd_cpu", {224'd0, o_rdata_cpu}, {224'd0, m_regs[i_raddr_cpu]});
            check("mdl_rd_ext", {224'd0, o_rdata_ext}, {224'd0, m_regs[i_raddr_ext]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_we_cpu = 1'b0;
        i_we_ext = 1'b0;
    endtask

    task automatic drive_cpu(input logic [7:0] a, input logic [31:0] d);
        i_we_cpu    = 1'b1;
        i_waddr_cpu = a;
        i_wdata_cpu = d;
    endtask

    task automatic drive_ext(input logic [2:0] a, input logic [31:0] d);
        i_we_ext    = 1'b1;
        i_waddr_ext = a;
        i_wdata_ext = d;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        check_en = 1'b1;

        // Fill every register with all-ones, then reset for two cycles.
        for (int k = 0; k < 8; k++) begin
            drive_ext(3'(k), 32'hFFFF_FFFF);
            tick();
        end
        idle();
        tick();
        check("lit_fill", o_regs, {256{1'b1}});
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        check("lit_rst_regs", o_regs, 256'd0);
        check("lit_rst_upd", {248'd0, o_upd}, 256'd0);
        check("lit_rst_rd_cpu", {224'd0, o_rdata_cpu}, 256'd0);
        check("lit_rst_rd_ext", {224'd0, o_rdata_ext}, 256'd0);

        // Core write and read-back on both ports.
        i_raddr_cpu = 3'd5;
        i_raddr_ext = 3'd5;
        drive_cpu(8'd5, 32'h1234_5678);
        tick();
        idle();
        check("lit_cpu_rd", {224'd0, o_rdata_cpu}, {224'd0, 32'h1234_5678});
        check("lit_ext_rd", {224'd0, o_rdata_ext}, {224'd0, 32'h1234_5678});
        check("lit_upd5", {248'd0, o_upd}, {248'd0, 8'b0010_0000});
        tick();
        check("lit_upd5_off", {248'd0, o_upd}, 256'd0);

        // Out-of-range core address.
        drive_cpu(8'h0D, 32'hDEAD_BEEF);
        tick();
        idle();
        check("lit_oor_regs", o_regs, {96'd0, 32'h1234_5678, 128'd0, 32'd0});
        check("lit_oor_upd", {248'd0, o_upd}, 256'd0);

        // Same-register collision: the core wins.
        i_raddr_cpu = 3'd3;
        i_raddr_ext = 3'd4;
        drive_cpu(8'd3, 32'hAAAA_0000);
        drive_ext(3'd3, 32'h5555_FFFF);
        tick();
        idle();
        check("lit_coll_rd", {224'd0, o_rdata_cpu}, {224'd0, 32'hAAAA_0000});
        check("lit_coll_upd", {248'd0, o_upd}, {248'd0, 8'b0000_1000});
        tick();
        check("lit_coll_upd_off", {248'd0, o_upd}, 256'd0);

        // Different-register collision: both writes land.
        drive_cpu(8'd3, 32'hAAAA_0000);
        drive_ext(3'd4, 32'h5555_FFFF);
        tick();
        idle();
        check("lit_dual_rd3", {224'd0, o_rdata_cpu}, {224'd0, 32'hAAAA_0000});
        check("lit_dual_rd4", {224'd0, o_rdata_ext}, {224'd0, 32'h5555_FFFF});
        check("lit_dual_upd", {248'd0, o_upd}, {248'd0, 8'b0001_1000});

        // No bypass: the old value is visible during the write cycle.
        i_raddr_cpu = 3'd1;
        drive_cpu(8'd1, 32'h0000_0042);
        #1;
        check("lit_nobyp_old", {224'd0, o_rdata_cpu}, 256'd0);
        tick();
        idle();
        check("lit_nobyp_new", {224'd0, o_rdata_cpu}, {224'd0, 32'h0000_0042});

        // Back-to-back writes to one register keep the strobe high.
        i_raddr_ext = 3'd2;
        drive_ext(3'd2, 32'h0000_0001);
        tick();
        check("lit_b2b_upd1", {248'd0, o_upd}, {248'd0, 8'b0000_0100});
        drive_ext(3'd2, 32'h0000_0002);
        tick();
        idle();
        check("lit_b2b_upd2", {248'd0, o_upd}, {248'd0, 8'b0000_0100});
        check("lit_b2b_val", {224'd0, o_rdata_ext}, {224'd0, 32'h0000_0002});
        tick();
        check("lit_b2b_off", {248'd0, o_upd}, 256'd0);

        // Rewriting an unchanged value still fires the strobe.
        drive_ext(3'd2, 32'h0000_0002);
        tick();
        idle();
        check("lit_same_upd", {248'd0, o_upd}, {248'd0, 8'b0000_0100});

        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 40; i++) begin
            i_we_cpu    = 1'($urandom_range(0, 1));
            i_waddr_cpu = 8'($urandom_range(0, 15));
            i_wdata_cpu = $urandom;
            i_we_ext    = 1'($urandom_range(0, 1));
            i_waddr_ext = 3'($urandom_range(0, 7));
            i_wdata_ext = $urandom;
            i_raddr_cpu = 3'($urandom_range(0, 7));
            i_raddr_ext = 3'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();

        // Reset overrides a host write in the same cycle.
        i_raddr_ext = 3'd7;
        drive_ext(3'd7, 32'h0000_0077);
        i_rst = 1'b1;
        tick();
        idle();
        i_rst = 1'b0;
        check("lit_midrst_rd7", {224'd0, o_rdata_ext}, 256'd0);
        check("lit_midrst_upd", {248'd0, o_upd}, 256'd0);
        check("lit_midrst_regs", o_regs, 256'd0);
        tick();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscq_user_regs.md
# riscq_user_regs

User register bank for the RISC-Q SoC. It holds eight 32-bit registers shared between the RISC-Q core and an external host such as the control or readout logic. The core writes through an 8-bit address port and reads through a 3-bit port. The host has its own independent write and read ports. Every register is also exposed in parallel, together with one update strobe per register, for downstream pulse and timing logic.

## Interface
- NUM_REGS, 8: number of registers; fixed, address space 0..7.
- DATA_W, 32: register width.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high; clock i_clk.
- i_we_cpu  in  1  core write enable.
- i_waddr_cpu  in  8  core write address; only 0..7 are decoded.
- i_wdata_cpu  in  32  core write data.
- i_raddr_cpu  in  3  core read address.
- o_rdata_cpu  out  32  core read data.
- i_we_ext  in  1  host write enable.
- i_waddr_ext  in  3  host write address.
- i_wdata_ext  in  32  host write data.
- i_raddr_ext  in  3  host read address.
- o_rdata_ext  out  32  host read data.
- o_regs  out  256  all registers concatenated; reg k occupies bits [32k+31:32k].
- o_upd  out  8  one-cycle strobe per register, bit k set the cycle after reg k was written.

## Operation
- Storage: eight 32-bit flops, reg0..reg7.
- Core write: when i_we_cpu=1 and i_waddr_cpu[7:3]=0, reg[i_waddr_cpu[2:0]] <= i_wdata_cpu.
  - Addresses 8..255 are ignored silently. No register changes and no strobe fires.
- Host write: when i_we_ext=1, reg[i_waddr_ext] <= i_wdata_ext.
- Simultaneous writes to different registers: both take effect in the same cycle.
- Simultaneous writes to the same register: the core write wins and the host write is dropped. o_upd fires once.
- Reads are combinational.
  - o_rdata_cpu = reg[i_raddr_cpu]; o_rdata_ext = reg[i_raddr_ext].
  - There is no write-to-read bypass: a read of a register written in the same cycle returns the old value.
- o_regs is a direct combinational view of the storage.
- o_upd[k] is registered. It is 1 in the cycle after any accepted write to reg k, including a write of the unchanged value, and 0 otherwise.

## Timing
- Reset: while i_rst=1 at a rising edge, all registers become 0 and o_upd becomes 0. Writes presented during that edge are ignored.
  - As a result, o_rdata_cpu, o_rdata_ext and o_regs read 0 after the reset edge.
- Reset asserted mid-operation: the same behaviour applies. It overrides any write in the same cycle.
- Write latency: a write sampled at edge N is visible on the read ports and o_regs after edge N, combinationally in cycle N+1.
- o_upd bit k is high for exactly cycle N+1.
- Read latency: zero cycles (combinational from address to data).
- Back-to-back writes to one register on consecutive cycles: each is accepted. The last value persists, and o_upd[k] stays high across the consecutive cycles.
- No handshake: the enables are single-cycle qualifiers and every accepted write completes in one cycle.

## Test plan
- Reset: hold i_rst for 2 cycles after writing 0xFFFFFFFF to all registers.
  - Required: all reads = 0, o_regs = 0, o_upd = 0.
- Core write/read: write 0x12345678 to address 5.
  - Required: o_rdata_cpu with raddr=5 = 0x12345678 next cycle; o_rdata_ext with raddr=5 is the same value.
  - Required: o_upd = 8'b0010_0000 for exactly one cycle.
- Out-of-range core address: write 0xDEADBEEF to address 0x0D.
  - Required: all registers unchanged (reg5 keeps 0x12345678); o_upd stays 0.
- Collision: in the same cycle, core writes 0xAAAA0000 to reg3 and host writes 0x5555FFFF to reg3.
  - Required: reg3 = 0xAAAA0000; o_upd[3] pulses once.
  - Repeat with host targeting reg4: both written, o_upd = 8'b0001_1000.
- No bypass: write 0x00000042 to reg1 while i_raddr_cpu=1.
  - Required: o_rdata_cpu shows the old value in the write cycle and 0x42 in the next.
- Reset mid-operation: assert i_rst in the same cycle as a host write of 0x77 to reg7.
  - Required: reg7 = 0, o_upd = 0.
